// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the memory-backed slave and its helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_t;

    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite signal bundle between the decoder/mux (master side) and one slave slot.
interface ahb_mem_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADYOUT;
    logic              HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_byte_lane_dec.sv
// Turns address low bits and HSIZE into a byte-lane enable mask, plus
// misalignment and oversize flags used for the ERROR decision.
module ahb_byte_lane_dec
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] addr_lo_i,
    input  hsize_t                      size_i,
    output logic [DATA_W/8-1:0]         be_o,
    output logic                        misalign_o,
    output logic                        oversize_o
);
    localparam int NB       = DATA_W / 8;
    localparam int MAX_SIZE = $clog2(NB);

    int  nbytes;
    int  base;
    logic osz;

    always_comb begin
        be_o       = '0;
        misalign_o = 1'b0;
        osz        = int'(size_i) > MAX_SIZE;
        nbytes     = 1 << size_i;
        base       = int'(addr_lo_i);
        if (!osz) begin
            misalign_o = (base & (nbytes - 1)) != 0;
            for (int i = 0; i < NB; i++) begin
                be_o[i] = (i >= base) && (i < base + nbytes);
            end
        end
    end

    assign oversize_o = osz;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory-backed slave: byte/halfword/word writes, configurable wait
// states on OKAY transfers and the standard two-cycle ERROR response.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no data phase pending, or zero-wait data phase in progress
// ST_WAIT | OKAY data phase: HREADYOUT low while counting, then one ready cycle
// ST_ERR1 | first ERROR cycle: HRESP=1, HREADYOUT=0
// ST_ERR2 | second ERROR cycle: HRESP=1, HREADYOUT=1
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_mem_slave_if.slave bus
);
    localparam int                NB        = DATA_W / 8;
    localparam int                LANE_W    = $clog2(NB);
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * NB);
    localparam logic [3:0]        WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    slv_state_t        state_q;
    logic [3:0]        wcnt_q;
    logic              hreadyout_q;
    logic              hresp_q;
    logic              dp_valid_q;
    logic              dp_write_q;
    logic [IDX_W-1:0]  idx_q;
    logic [NB-1:0]     be_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [NB-1:0]     be_d;
    logic              misalign;
    logic              oversize;
    logic              accept;
    logic              err_acc;
    logic              wr_en;

    ahb_byte_lane_dec #(
        .DATA_W (DATA_W)
    ) u_lane_dec (
        .addr_lo_i  (bus.HADDR[LANE_W-1:0]),
        .size_i     (hsize_t'(bus.HSIZE)),
        .be_o       (be_d),
        .misalign_o (misalign),
        .oversize_o (oversize)
    );

    // A new address phase can only land in a cycle where our own data phase is completing.
    assign accept  = bus.HSEL && bus.HREADY && hreadyout_q && htrans_active(bus.HTRANS);
    assign err_acc = (bus.HADDR >= MEM_BYTES) || misalign || oversize;
    assign wr_en   = dp_valid_q && dp_write_q && hreadyout_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            idx_q       <= '0;
            be_q        <= '0;
        end else if (hreadyout_q) begin
            if (accept) begin
                idx_q      <= bus.HADDR[LANE_W +: IDX_W];
                be_q       <= be_d;
                dp_write_q <= bus.HWRITE;
                if (err_acc) begin
                    state_q     <= ST_ERR1;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= HRESP_ERROR;
                    dp_valid_q  <= 1'b0;
                end else if (WAIT_STATES > 0) begin
                    state_q     <= ST_WAIT;
                    wcnt_q      <= WAIT_LOAD;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= HRESP_OKAY;
                    dp_valid_q  <= 1'b1;
                end else begin
                    state_q     <= ST_IDLE;
                    hresp_q     <= HRESP_OKAY;
                    dp_valid_q  <= 1'b1;
                end
            end else begin
                state_q    <= ST_IDLE;
                hresp_q    <= HRESP_OKAY;
                dp_valid_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (wcnt_q == 4'd0) begin
                        hreadyout_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    dp_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Read data comes straight from the array so a write committing on the
    // previous edge is already visible to a back-to-back read.
    assign bus.HRDATA    = (dp_valid_q && !dp_write_q && hreadyout_q) ? mem_q[idx_q] : '0;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: a zero-wait and a three-wait instance driven through
// shared stimulus, checked against a byte-addressed reference memory.
module tb_ahb_mem_slave;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        hsel   = 1'b0;
    logic        hwrite = 1'b0;
    logic        use3   = 1'b0;
    logic        stall  = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize  = 3'd2;
    logic [31:0] haddr  = '0;
    logic [31:0] hwdata = '0;

    logic        hready_m;
    logic        hresp_m;
    logic [31:0] hrdata_m;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [7:0]  refm [2][1024];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    ahb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

    assign if0.HSEL   = hsel & ~use3;
    assign if0.HADDR  = haddr;
    assign if0.HTRANS = htrans;
    assign if0.HWRITE = hwrite;
    assign if0.HSIZE  = hsize;
    assign if0.HWDATA = hwdata;
    assign if0.HREADY = if0.HREADYOUT & ~stall;

    assign if3.HSEL   = hsel & use3;
    assign if3.HADDR  = haddr;
    assign if3.HTRANS = htrans;
    assign if3.HWRITE = hwrite;
    assign if3.HSIZE  = hsize;
    assign if3.HWDATA = hwdata;
    assign if3.HREADY = if3.HREADYOUT;

    assign hready_m = use3 ? if3.HREADYOUT : if0.HREADYOUT;
    assign hresp_m  = use3 ? if3.HRESP     : if0.HRESP;
    assign hrdata_m = use3 ? if3.HRDATA    : if0.HRDATA;

    ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if0.slave)
    );

    ahb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (if3.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; starts and ends just after a falling edge.
    task automatic xfer(input int m, input bit wr, input int a, input logic [2:0] sz,
                        input logic [31:0] wd, input string tag);
        int          low;
        logic        lresp;
        logic [31:0] lrd;
        logic [31:0] rd;
        logic        rsp;
        logic        done;
        bit          err;
        logic [31:0] exp_rd;
        int          wb;
        use3   = (m != 0);
        hsel   = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = 32'(a);
        hsize  = sz;
        @(negedge clk);
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wd;
        low    = 0;
        lresp  = 1'b0;
        lrd    = '0;
        while (!hready_m && low < 40) begin
            low++;
            lresp = lresp | hresp_m;
            lrd   = lrd | hrdata_m;
            @(negedge clk);
        end
        done = hready_m;
        rd   = hrdata_m;
        rsp  = hresp_m;
        @(negedge clk);

        err    = (a >= 1024) || (sz > 3'd2) || ((a % (1 << sz)) != 0);
        exp_rd = '0;
        if (!err && !wr) begin
            wb     = a - (a % 4);
            exp_rd = {refm[m][wb+3], refm[m][wb+2], refm[m][wb+1], refm[m][wb]};
        end
        if (!err && wr) begin
            for (int k = 0; k < (1 << sz); k++) begin
                refm[m][a+k] = wd[8*((a+k)%4) +: 8];
            end
        end
        last_rd = rd;
        chk({tag, ".done"},    32'(done),  32'd1);
        chk({tag, ".lowcyc"},  32'(low),   err ? 32'd1 : ((m != 0) ? 32'd3 : 32'd0));
        chk({tag, ".resp"},    32'(rsp),   32'(err));
        chk({tag, ".rdata"},   rd,         exp_rd);
        chk({tag, ".lowresp"}, 32'(lresp), 32'(err));
        chk({tag, ".lowdata"}, lrd,        32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a;
        int          kind;
        logic [2:0]  sz;
        bit          wr;

        // reset values on both instances
        repeat (2) @(negedge clk);
        use3 = 1'b0; #1;
        chk("rst0.ready", 32'(hready_m), 32'd1);
        chk("rst0.resp",  32'(hresp_m),  32'd0);
        chk("rst0.rdata", hrdata_m,      32'd0);
        use3 = 1'b1; #1;
        chk("rst3.ready", 32'(hready_m), 32'd1);
        chk("rst3.resp",  32'(hresp_m),  32'd0);
        chk("rst3.rdata", hrdata_m,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE and BUSY transfers get a zero-wait OKAY
        for (int m = 0; m < 2; m++) begin
            use3   = (m != 0);
            hsel   = 1'b1;
            for (int t = 0; t < 3; t++) begin
                htrans = (t == 2) ? 2'b01 : 2'b00;
                @(negedge clk);
                chk("idle.ready", 32'(hready_m), 32'd1);
                chk("idle.resp",  32'(hresp_m),  32'd0);
            end
            hsel   = 1'b0;
            htrans = 2'b00;
        end

        // fill the low region of both memories so every later read is defined
        for (int w = 0; w < 64; w++) begin
            xfer(0, 1'b1, w*4, 3'd2, $urandom, "init0");
            xfer(1, 1'b1, w*4, 3'd2, $urandom, "init3");
        end

        // pipelined write then read of the same word, zero wait states
        use3   = 1'b0;
        hsel   = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        @(negedge clk);
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        chk("b2b.wr_ready", 32'(hready_m), 32'd1);
        chk("b2b.wr_resp",  32'(hresp_m),  32'd0);
        @(negedge clk);
        hsel   = 1'b0; htrans = 2'b00;
        chk("b2b.rd_ready", 32'(hready_m), 32'd1);
        chk("b2b.rd_data",  hrdata_m,      32'hDEADBEEF);
        @(negedge clk);
        refm[0][16] = 8'hEF; refm[0][17] = 8'hBE; refm[0][18] = 8'hAD; refm[0][19] = 8'hDE;

        // byte merge into an existing word
        xfer(0, 1'b1, 32'h10, 3'd2, 32'h11223344, "merge.w");
        xfer(0, 1'b1, 32'h13, 3'd0, 32'h5A000000, "merge.b");
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0,        "merge.r");
        chk("merge.value", last_rd, 32'h5A223344);

        // three wait states: low for exactly three cycles, data on the fourth
        xfer(1, 1'b1, 32'h80, 3'd2, 32'hA5A50F0F, "ws3.w");
        xfer(1, 1'b0, 32'h80, 3'd2, 32'h0,        "ws3.r");
        chk("ws3.value", last_rd, 32'hA5A50F0F);

        // out-of-range, misaligned and oversize transfers
        xfer(0, 1'b0, 32'h400, 3'd2, 32'h0,        "oor0");
        xfer(1, 1'b0, 32'h400, 3'd2, 32'h0,        "oor3");
        xfer(0, 1'b1, 32'h01,  3'd1, 32'hFFFFFFFF, "mis.w");
        xfer(0, 1'b0, 32'h00,  3'd2, 32'h0,        "mis.r");
        xfer(0, 1'b1, 32'h08,  3'd3, 32'hFFFFFFFF, "osz.w");
        xfer(0, 1'b0, 32'h08,  3'd2, 32'h0,        "osz.r");

        // address phase while HREADY is held low elsewhere must be ignored
        use3   = 1'b0;
        stall  = 1'b1;
        hsel   = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h20; hsize = 3'd2;
        @(negedge clk);
        stall  = 1'b0; hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
        chk("stall.ready", 32'(hready_m), 32'd1);
        @(negedge clk);
        xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, "stall.r");

        // asynchronous reset in the middle of a wait-state data phase
        use3   = 1'b1;
        hsel   = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h40; hsize = 3'd2;
        @(negedge clk);
        hsel   = 1'b0; htrans = 2'b00;
        chk("mrst.waiting", 32'(hready_m), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.ready", 32'(hready_m), 32'd1);
        chk("mrst.resp",  32'(hresp_m),  32'd0);
        chk("mrst.rdata", hrdata_m,      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1, 1'b0, 32'h40, 3'd2, 32'h0, "mrst.after");

        // randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            sz   = 3'($urandom_range(0, 2));
            a    = int'($urandom_range(0, 255)) & ~((1 << sz) - 1);
            if (kind == 0) begin
                a = 32'h400 + int'($urandom_range(0, 63)) * 4;
            end else if (kind == 1) begin
                sz = 3'($urandom_range(1, 2));
                a  = int'($urandom_range(0, 63)) * 4 + 1;
            end else if (kind == 2) begin
                sz = 3'd3;
            end
            wr = 1'($urandom_range(0, 1));
            xfer(n % 2, wr, a, sz, $urandom, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
